// File: rtl/mrd_inv_col_seq.sv
// Minimal-residual-descent solver for one column of an approximate inverse: row-serial dot products,
// restoring divider for alpha, parallel m update. Optional early stop on residual norm: MRD_EARLY_STOP_EN.
module mrd_inv_col_seq #(
    parameter int DIMENSION = 16,
    parameter int WIDTH     = 16,
    parameter int FRAC      = 8,
    parameter int ITER_W    = 4,
    parameter int TOL_SQ    = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic                                 start,
    input  logic [DIMENSION*DIMENSION*WIDTH-1:0] a_flat,
    input  logic [$clog2(DIMENSION)-1:0]         col_sel,
    input  logic [DIMENSION*WIDTH-1:0]           m_init,
    input  logic [ITER_W-1:0]                    iter_max,
    output logic [DIMENSION*WIDTH-1:0]           m_out,
    output logic                                 busy,
    output logic                                 done,
    output logic [ITER_W-1:0]                    iter_cnt,
    output logic                                 zero_div,
    output logic                                 converged
);
    localparam int IDX_W = $clog2(DIMENSION);
    localparam int ACC_W = 2*WIDTH + IDX_W;
    localparam int SAT_W = ACC_W + 2;
    localparam int DIV_W = ACC_W + WIDTH + 2;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic signed [SAT_W-1:0] MAX_S = SAT_W'((2**(WIDTH-1)) - 1);
    localparam logic signed [SAT_W-1:0] MIN_S = -MAX_S - SAT_W'(1);
    localparam logic signed [SAT_W-1:0] ONE_S = SAT_W'(1 << FRAC);

    typedef enum logic [2:0] {S_IDLE, S_RES, S_AQ, S_DIV, S_UPD, S_DONE} state_t;
    state_t state_reg, state_next;

    logic signed [WIDTH-1:0]  m_reg [DIMENSION];
    logic signed [WIDTH-1:0]  r_reg [DIMENSION];
    logic [IDX_W-1:0]         row_reg, col_reg;
    logic [ITER_W-1:0]        iter_max_reg, iter_cnt_reg;
    logic signed [ACC_W-1:0]  num_reg;
    logic [ACC_W-1:0]         den_reg;
    logic [CNT_W-1:0]         div_cnt_reg;
    logic [DIV_W-1:0]         rem_reg;
    logic [WIDTH-1:0]         quo_reg;
    logic                     ovf_reg;
    logic signed [WIDTH-1:0]  alpha_reg;
    logic                     zero_div_reg, converged_reg;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [SAT_W-1:0] x);
        if (x > MAX_S)      return MAX_S[WIDTH-1:0];
        else if (x < MIN_S) return MIN_S[WIDTH-1:0];
        else                return x[WIDTH-1:0];
    endfunction

    function automatic logic signed [SAT_W-1:0] ext_prod(input logic signed [2*WIDTH-1:0] p);
        return {{(SAT_W-2*WIDTH){p[2*WIDTH-1]}}, p};
    endfunction

    function automatic logic signed [SAT_W-1:0] ext_w(input logic signed [WIDTH-1:0] v);
        return {{(SAT_W-WIDTH){v[WIDTH-1]}}, v};
    endfunction

    // Row-serial dot product: the selected row of A against m (RES) or r (AQ).
    logic [DIMENSION*WIDTH-1:0] a_rows [DIMENSION];
    logic signed [WIDTH-1:0]    a_elem [DIMENSION];
    logic signed [WIDTH-1:0]    vec    [DIMENSION];
    logic signed [2*WIDTH-1:0]  prod   [DIMENSION];
    logic signed [2*WIDTH-1:0]  ar     [DIMENSION];
    logic signed [WIDTH-1:0]    m_upd  [DIMENSION];

    generate
        for (genvar gi = 0; gi < DIMENSION; gi++) begin : g_lane
            assign a_rows[gi] = a_flat[gi*DIMENSION*WIDTH +: DIMENSION*WIDTH];
            assign a_elem[gi] = a_rows[row_reg][gi*WIDTH +: WIDTH];
            assign vec[gi]    = (state_reg == S_AQ) ? r_reg[gi] : m_reg[gi];
            assign prod[gi]   = a_elem[gi] * vec[gi];
            assign ar[gi]     = alpha_reg * r_reg[gi];
            assign m_upd[gi]  = sat(ext_w(m_reg[gi]) + ext_w(sat(ext_prod(ar[gi]) >>> FRAC)));
            assign m_out[gi*WIDTH +: WIDTH] = m_reg[gi];
        end
    endgenerate

    logic signed [SAT_W-1:0]   dot, dot_sh, e_val;
    logic signed [WIDTH-1:0]   r_new, q_new;
    logic signed [2*WIDTH-1:0] rq, qq;
    logic signed [ACC_W-1:0]   num_next;
    logic [ACC_W-1:0]          den_next;

    always_comb begin
        dot = '0;
        for (int j = 0; j < DIMENSION; j++) begin
            dot = dot + ext_prod(prod[j]);
        end
    end

    assign dot_sh   = dot >>> FRAC;
    assign e_val    = (row_reg == col_reg) ? ONE_S : '0;
    assign r_new    = sat(e_val - dot_sh);
    assign q_new    = sat(dot_sh);
    assign rq       = r_reg[row_reg] * q_new;
    assign qq       = q_new * q_new;
    assign num_next = num_reg + {{IDX_W{rq[2*WIDTH-1]}}, rq};
    assign den_next = den_reg + {{IDX_W{1'b0}}, qq};

    // Restoring divide of |num|<<FRAC by den, one quotient bit per cycle from bit WIDTH down to 0.
    // Any quotient at or above 2^(WIDTH+1) is flagged up front and saturates.
    logic [ACC_W-1:0]        num_mag;
    logic [DIV_W-1:0]        dvd, rem_cur, den_ext, den_sh, rem_nxt;
    logic [CNT_W-1:0]        bit_pos;
    logic                    sub_ok, ovf_now, num_neg;
    logic [WIDTH:0]          quo_nxt;
    logic signed [SAT_W-1:0] quo_signed;
    logic signed [WIDTH-1:0] alpha_new;

    assign num_neg    = num_reg[ACC_W-1];
    assign num_mag    = num_neg ? ACC_W'(-num_reg) : ACC_W'(num_reg);
    assign dvd        = {{(DIV_W-ACC_W-FRAC){1'b0}}, num_mag, {FRAC{1'b0}}};
    assign rem_cur    = (div_cnt_reg == '0) ? dvd : rem_reg;
    assign den_ext    = {{(DIV_W-ACC_W){1'b0}}, den_reg};
    assign bit_pos    = CNT_W'(WIDTH) - div_cnt_reg;
    assign den_sh     = den_ext << bit_pos;
    assign sub_ok     = rem_cur >= den_sh;
    assign rem_nxt    = sub_ok ? rem_cur - den_sh : rem_cur;
    assign ovf_now    = (div_cnt_reg == '0) ? (rem_cur >= (den_ext << (WIDTH + 1))) : ovf_reg;
    assign quo_nxt    = {quo_reg, sub_ok};
    assign quo_signed = ovf_now ? (num_neg ? MIN_S : MAX_S)
                      : (num_neg ? -$signed({{(SAT_W-WIDTH-1){1'b0}}, quo_nxt})
                                 :  $signed({{(SAT_W-WIDTH-1){1'b0}}, quo_nxt}));
    assign alpha_new  = (den_reg == '0) ? '0 : sat(quo_signed);

    logic row_last, div_last, stop_now;
    assign row_last = (row_reg == IDX_W'(DIMENSION - 1));
    assign div_last = (div_cnt_reg == CNT_W'(WIDTH));

`ifdef MRD_EARLY_STOP_EN
    logic [ACC_W-1:0]          rn_reg, rn_next;
    logic signed [2*WIDTH-1:0] rr;
    assign rr       = r_new * r_new;
    assign rn_next  = rn_reg + {{IDX_W{1'b0}}, rr};
    assign stop_now = (rn_next <= ACC_W'(TOL_SQ));

    always_ff @(posedge clk) begin
        if (rst) begin
            rn_reg <= '0;
        end else if (en) begin
            if (state_reg == S_RES) rn_reg <= row_last ? '0 : rn_next;
            else if (state_reg == S_IDLE) rn_reg <= '0;
        end
    end
`else
    assign stop_now = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)     state_reg <= S_IDLE;
        else if (en) state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (start) state_next = (iter_max == '0) ? S_DONE : S_RES;
            S_RES:  if (row_last) state_next = stop_now ? S_DONE : S_AQ;
            S_AQ:   if (row_last) state_next = S_DIV;
            S_DIV:  if (div_last) state_next = (den_reg == '0) ? S_DONE : S_UPD;
            S_UPD:  state_next = (iter_cnt_reg + 1'b1 == iter_max_reg) ? S_DONE : S_RES;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIMENSION; i++) begin
                m_reg[i] <= '0;
                r_reg[i] <= '0;
            end
            row_reg       <= '0;
            col_reg       <= '0;
            iter_max_reg  <= '0;
            iter_cnt_reg  <= '0;
            num_reg       <= '0;
            den_reg       <= '0;
            div_cnt_reg   <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            ovf_reg       <= 1'b0;
            alpha_reg     <= '0;
            zero_div_reg  <= 1'b0;
            converged_reg <= 1'b0;
        end else if (en) begin
            case (state_reg)
                S_IDLE: if (start) begin
                    for (int i = 0; i < DIMENSION; i++) m_reg[i] <= m_init[i*WIDTH +: WIDTH];
                    col_reg       <= col_sel;
                    iter_max_reg  <= iter_max;
                    iter_cnt_reg  <= '0;
                    zero_div_reg  <= 1'b0;
                    converged_reg <= 1'b0;
                    row_reg       <= '0;
                end
                S_RES: begin
                    r_reg[row_reg] <= r_new;
                    row_reg        <= row_last ? '0 : row_reg + 1'b1;
                    if (row_last) begin
                        num_reg <= '0;
                        den_reg <= '0;
                        if (stop_now) converged_reg <= 1'b1;
                    end
                end
                S_AQ: begin
                    num_reg     <= num_next;
                    den_reg     <= den_next;
                    row_reg     <= row_last ? '0 : row_reg + 1'b1;
                    div_cnt_reg <= '0;
                end
                S_DIV: begin
                    rem_reg     <= rem_nxt;
                    quo_reg     <= quo_nxt[WIDTH-1:0];
                    ovf_reg     <= ovf_now;
                    div_cnt_reg <= div_cnt_reg + 1'b1;
                    if (div_last) begin
                        alpha_reg <= alpha_new;
                        if (den_reg == '0) zero_div_reg <= 1'b1;
                    end
                end
                S_UPD: begin
                    for (int i = 0; i < DIMENSION; i++) m_reg[i] <= m_upd[i];
                    iter_cnt_reg <= iter_cnt_reg + 1'b1;
                    row_reg      <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign done      = (state_reg == S_DONE);
    assign iter_cnt  = iter_cnt_reg;
    assign zero_div  = zero_div_reg;
    assign converged = converged_reg;

endmodule

// File: tb/tb_mrd_inv_col_seq.sv
// Directed-vector bench for mrd_inv_col_seq: the driver queues hand-computed results,
// a done-edge monitor pops and compares them.
module tb_mrd_inv_col_seq;
    localparam int N  = 16;
    localparam int W  = 16;
    localparam int IW = 4;
    localparam int L  = 2*N + W + 2;
`ifdef MRD_EARLY_STOP_EN
    localparam bit ES = 1'b1;
`else
    localparam bit ES = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, en, start;
    logic [N*N*W-1:0] a_flat;
    logic [3:0]       col_sel;
    logic [N*W-1:0]   m_init;
    logic [IW-1:0]    iter_max;
    logic [N*W-1:0]   m_out;
    logic             busy, done, zero_div, converged;
    logic [IW-1:0]    iter_cnt;

    mrd_inv_col_seq #(.DIMENSION(N), .WIDTH(W), .FRAC(8), .ITER_W(IW), .TOL_SQ(16)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .a_flat(a_flat), .col_sel(col_sel),
        .m_init(m_init), .iter_max(iter_max), .m_out(m_out), .busy(busy), .done(done),
        .iter_cnt(iter_cnt), .zero_div(zero_div), .converged(converged)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N*W-1:0] m;
        int             it;
        bit             zd;
        bit             cv;
        int             lat;
        int             t0;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    function automatic logic [N*N*W-1:0] diag(input logic [W-1:0] d);
        logic [N*N*W-1:0] a = '0;
        for (int i = 0; i < N; i++) a[(i*N+i)*W +: W] = d;
        return a;
    endfunction

    function automatic logic [N*W-1:0] one_hot(input int idx, input logic [W-1:0] v);
        logic [N*W-1:0] m = '0;
        m[idx*W +: W] = v;
        return m;
    endfunction

    // Monitor: one comparison set per rising edge of done.
    logic done_q = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done && !done_q) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no job", cyc);
            end else begin
                e = sb.pop_front();
                chk("m_out", m_out, e.m);
                chk("iter_cnt", iter_cnt, e.it);
                chk("zero_div", zero_div, e.zd);
                chk("converged", converged, e.cv);
                chk("busy_at_done", busy, 1'b0);
                if (e.lat >= 0) chk("latency", cyc - e.t0, e.lat);
            end
        end
        done_q <= done;
    end

    task automatic run_job(input logic [N*N*W-1:0] a, input int col, input logic [N*W-1:0] mi,
                           input int im, input logic [N*W-1:0] em, input int eit, input bit ezd,
                           input bit ecv, input int elat, input bit toggle);
        exp_t e;
        int   n;
        bit   seen;
        @(negedge clk);
        a_flat = a; col_sel = 4'(col); m_init = mi; iter_max = IW'(im);
        en = 1'b1; start = 1'b1;
        e.m = em; e.it = eit; e.zd = ezd; e.cv = ecv; e.lat = elat; e.t0 = cyc + 1;
        sb.push_back(e);
        n = 0; seen = 1'b0;
        while (!seen && n < 3000) begin
            @(negedge clk);
            n++;
            if (toggle) en = ~en;
            if (done) seen = 1'b1;
            else if (!toggle) start = 1'b0;
        end
        if (!seen) begin
            checks++;
            $display("FAIL timeout: got no done after %0d cycles expected done", n);
        end
        // Start stays high through the DONE cycle; it must be ignored there.
        en = 1'b1;
        @(negedge clk);
        chk("done_pulse", done, 1'b0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after", busy, 1'b0);
    endtask

    logic [N*N*W-1:0] a_nd;
    logic [N*W-1:0]   m_mix;

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0;
        a_flat = '0; col_sel = '0; m_init = '0; iter_max = '0;
        repeat (3) @(negedge clk);
        chk("rst_m_out", m_out, '0);
        chk("rst_iter_cnt", iter_cnt, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_flags", {zero_div, converged}, 2'b00);
        rst = 1'b0;

        run_job(diag(16'h0100), 0, '0, 1, one_hot(0, 16'h0100), 1, 0, 0, L, 0);
        run_job(diag(16'h0200), 3, '0, 1, one_hot(3, 16'h0080), 1, 0, 0, L, 0);
        m_mix = one_hot(1, 16'h0100) | one_hot(2, 16'hFFFB);
        run_job('0, 2, m_mix, 3, m_mix, 0, 1, 0, -1, 0);
        run_job(diag(16'h0100), 0, '0, 2, one_hot(0, 16'h0100), 1, !ES, ES, -1, 0);
        run_job(diag(16'h0100), 4, one_hot(7, 16'd77), 0, one_hot(7, 16'd77), 0, 0, 0, 0, 0);
        run_job(diag(16'h0001), 0, '0, 1, one_hot(0, 16'h7FFF), 1, 0, 0, L, 0);
        run_job(diag(16'hFFFF), 5, '0, 1, one_hot(5, 16'h8000), 1, 0, 0, L, 0);
        run_job(diag(16'hFFFD), 0, '0, 1, one_hot(0, 16'hAAAB), 1, 0, 0, L, 0);
        run_job(diag(16'h0100), 1, one_hot(1, 16'h0080), 1, one_hot(1, 16'h0100), 1, 0, 0, L, 0);
        a_nd = diag(16'h0100);
        a_nd[(1*N+0)*W +: W] = 16'h0100;
        run_job(a_nd, 0, '0, 1, one_hot(0, 16'h0080), 1, 0, 0, L, 0);

        // Abort a job in AQ with a reset, then rerun a clean job.
        @(negedge clk);
        a_flat = diag(16'h0100); col_sel = 4'd0; m_init = one_hot(5, 16'h1234); iter_max = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("busy_mid_job", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_m_out", m_out, '0);
        chk("abort_iter_cnt", iter_cnt, '0);
        chk("abort_busy_done", {busy, done}, 2'b00);
        chk("abort_flags", {zero_div, converged}, 2'b00);
        run_job(diag(16'h0200), 3, '0, 1, one_hot(3, 16'h0080), 1, 0, 0, L, 0);

        // en toggled every cycle with start held: same result, twice the latency.
        run_job(diag(16'h0100), 0, '0, 1, one_hot(0, 16'h0100), 1, 0, 0, 2*L, 1);

`ifdef MRD_EARLY_STOP_EN
        run_job(diag(16'h0100), 0, one_hot(0, 16'h0100), 5, one_hot(0, 16'h0100), 0, 0, 1, N, 0);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end by cycle %0d expected finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
